bit_serial_adder: RTL
=====================

Name: bit_serial_adder

Overview:
- Adds two WIDTH-bit operands one bit per clock, LSB first.
- A single registered full-adder cell is used: each cycle's carry-out is stored in a flip-flop and fed back as the next cycle's carry-in.
- Sits downstream of the operand source and wraps the 1-bit full-adder datapath in shift registers, a bit counter and a start/done handshake.
- Trades latency (WIDTH cycles) for area: one adder cell instead of WIDTH.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  initial carry, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  result; holds until the next accepted start
- cout  output  1  final carry-out
- ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0, ovf=0
  - bit counter=0, carry FF=0, operand shift registers=0
- Reset takes effect mid-operation immediately; the partial result is discarded and no done is produced.
- States:
  - IDLE: busy=0. On start=1, capture a, b and cin into the carry FF, clear the counter and go to ADD.
  - ADD: busy=1. Each edge:
    - s = a_sr[0]^b_sr[0]^carry; c = maj(a_sr[0], b_sr[0], carry)
    - s shifts into the sum register from the MSB side; a_sr and b_sr shift right
    - carry<=c; counter increments
    - When counter reaches WIDTH-1, process that final bit, then go to DONE with cout<=c.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 here is accepted (back-to-back) and goes to ADD.
    - Otherwise go to IDLE.
- Latency: start sampled at edge k; done high in the cycle following edge k+WIDTH. Total of WIDTH cycles in ADD.
- start while busy=1 is ignored, with no queuing.
- sum, cout and ovf are stable from DONE until the next accepted start.
  - On an accepted start they may change during ADD.
  - Consumers must sample only on done.
- Arithmetic is modulo 2^WIDTH; cout carries the bit-WIDTH carry.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BIT_SERIAL_ADD_OVF_EN
- Defined:
  - The carry into the MSB (the carry FF value when counter=WIDTH-1) is captured.
  - ovf is registered as that carry XOR the final cout, valid with done.
- Undefined:
  - The capture logic is not built; ovf is tied to 0.
  - The port still exists.

Decomposition:
- Shared package bit_serial_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADD, DONE} bsa_state_t
  - localparam function for counter width, $clog2(WIDTH)
- One natural sub-module: serial_fa_cell.
  - Contains the combinational 1-bit full adder (s, c from x, y, ci) plus the carry flip-flop.
  - Carry FF has the same async active-low reset, plus a synchronous load of cin on start.
  - The top level holds the FSM, counter and shift registers.

Test Plan (WIDTH=8):
- Reset: rst_n=0 with random inputs -> all outputs 0. Release, then start=1, a=0x5A, b=0x3C, cin=0 -> done exactly 8 cycles after start edge, sum=0x96, cout=0, ovf=1 (ovf 0 if macro undefined).
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Start while busy: start=1 with a=0x01, b=0x01; pulse start with a=0xF0, b=0x0F during cycle 3 of ADD -> ignored; result sum=0x02, single done.
- Back-to-back: assert start in the DONE cycle with a=0x80, b=0x80, cin=0 -> busy high next cycle, no IDLE gap; second done gives sum=0x00, cout=1, ovf=1.
- Reset mid-op: drop rst_n in cycle 4 of ADD -> outputs 0 immediately, no done. After release, a=0x12, b=0x34 -> sum=0x46, cout=0.
- Hold: after done, toggle a/b without start for 20 cycles -> sum/cout/ovf unchanged, busy=0, done=0.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// bit_serial_pkg: shared FSM state type and sizing helper for the bit-serial adder
package bit_serial_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} bsa_state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: 1-bit full adder whose carry-out is registered and fed back as carry-in
module serial_fa_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic cin,
  input  logic en,
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  logic carry;
  assign s = x ^ y ^ carry;
  assign c = (x & y) | (x & carry) | (y & carry);
  // carry FF: seeded with cin when an operation starts, then tracks carry-out each bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) carry <= 1'b0;
    else if (load) carry <= cin;
    else if (en) carry <= c;
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder, one bit per clock; BIT_SERIAL_ADD_OVF_EN enables signed overflow
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  bsa_state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic accept, adding, last, s, c;
  assign accept = start && state != ADD;
  assign adding = state == ADD;
  assign last = adding && cnt == LAST;
  serial_fa_cell u_fa (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .cin  (cin),
    .en   (adding),
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .s    (s),
    .c    (c)
  );
  // next state: DONE accepts a new start directly so back-to-back ops have no IDLE gap
  always_comb begin
    state_nx = state;
    state_nx = state == ADD ? (last ? DONE : ADD) : (start ? ADD : IDLE);
  end
  // state register, with busy/done registered from the next state so they are glitch-free flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= state_nx == ADD;
      done  <= state_nx == DONE;
    end
  // operand shift-out, sum shift-in from the MSB side, bit counter and final carry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      cnt  <= '0;
    end else if (adding) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      sum  <= {s, sum[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      if (last) cout <= c;
    end
`ifdef BIT_SERIAL_ADD_OVF_EN
  // carry into the MSB equals s^x^y of the last bit; overflow is that carry xor the final carry-out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (last) ovf <= (s ^ a_sr[0] ^ b_sr[0]) ^ c;
`else
  assign ovf = 1'b0;
`endif
endmodule
